pbit_sweep_scheduler: RTL and testbench



---
 rtl/pbit_pkg.sv | 23 ++
 rtl/pbit_next_sel.sv | 21 ++
 rtl/pbit_sweep_scheduler.sv | 121 ++++++++++++
 tb/tb_pbit_sweep_scheduler.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pbit_pkg.sv
// Shared types and helpers for the p-bit sweep scheduler.
package pbit_pkg;
  localparam int N_DEF  = 5;
  localparam int DW_DEF = 4;
  localparam int SW_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DWELL,
    S_GAP,
    S_SWEEP_END,
    S_DONE
  } sched_state_t;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic int lowest_set(input logic [31:0] v);
    int r;
    r = 0;
    for (int i = 31; i >= 0; i--)
      if (v[i]) r = i;
    return r;
  endfunction
endpackage

// File: rtl/pbit_next_sel.sv
// Finds the next enabled p-bit strictly above idx; wrap flags the end of a sweep.
module pbit_next_sel #(
  parameter int N  = 5,
  parameter int IW = 3
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] idx,
  output logic [IW-1:0] nxt,
  output logic          wrap
);
  // Descending scan so the lowest qualifying index is the last one written.
  always_comb begin
    nxt  = '0;
    wrap = 1'b1;
    for (int i = N - 1; i >= 0; i--)
      if (mask[i] && i > int'(idx)) begin
        nxt  = IW'(i);
        wrap = 1'b0;
      end
  end
endmodule

// File: rtl/pbit_sweep_scheduler.sv
// Masked round-robin update scheduler with programmable dwell/gap and sweep counting.
module pbit_sweep_scheduler
  import pbit_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF,
  parameter int SW = SW_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start,
  input  logic          stop,
  input  logic [N-1:0]  enable_mask,
  input  logic [DW-1:0] dwell_cycles,
  input  logic [DW-1:0] gap_cycles,
  input  logic [SW-1:0] num_sweeps,
  output logic [N-1:0]  update_en,
  output logic          busy,
  output logic          sample_valid,
  output logic [SW-1:0] sweep_count,
  output logic          done
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  sched_state_t  state, state_n;
  logic [N-1:0]  mask_q;
  logic [DW-1:0] dwell_q, gap_q, cnt, cnt_n, dw_ld;
  logic [SW-1:0] nsw_q, sc_n;
  logic [IW-1:0] idx, idx_n, nxt;
  logic          wrap, latch;

  pbit_next_sel #(.N(N), .IW(IW)) u_next (
    .mask (mask_q),
    .idx  (idx),
    .nxt  (nxt),
    .wrap (wrap)
  );

  // Dwell reload value: a programmed 0 behaves as 1 cycle.
  assign dw_ld = (dwell_q == '0) ? '0 : dwell_q - DW'(1);

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    sc_n    = sweep_count;
    latch   = 1'b0;
    case (state)
      S_IDLE:
        if (start) begin
          latch = 1'b1;
          sc_n  = '0;
          if (enable_mask == '0) state_n = S_DONE;
          else begin
            state_n = S_DWELL;
            idx_n   = IW'(lowest_set(32'(enable_mask)));
            cnt_n   = (dwell_cycles == '0) ? '0 : dwell_cycles - DW'(1);
          end
        end
      S_DWELL, S_GAP:
        if (cnt != '0) cnt_n = cnt - DW'(1);
        else if (state == S_DWELL && gap_q != '0) begin
          state_n = S_GAP;
          cnt_n   = gap_q - DW'(1);
        end else if (!wrap) begin
          state_n = S_DWELL;
          idx_n   = nxt;
          cnt_n   = dw_ld;
        end else state_n = S_SWEEP_END;
      S_SWEEP_END: begin
        sc_n = (&sweep_count) ? sweep_count : sweep_count + SW'(1);
        if (nsw_q != '0 && sc_n == nsw_q) state_n = S_DONE;
        else begin
          state_n = S_DWELL;
          idx_n   = IW'(lowest_set(32'(mask_q)));
          cnt_n   = dw_ld;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    // Abort overrides everything, including a pending sweep-end increment.
    if (stop && state != S_IDLE) begin
      state_n = S_IDLE;
      sc_n    = sweep_count;
    end
  end

  // Outputs are flopped from the next-state decode so they align with the state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= S_IDLE;
      mask_q       <= '0;
      dwell_q      <= '0;
      gap_q        <= '0;
      nsw_q        <= '0;
      idx          <= '0;
      cnt          <= '0;
      sweep_count  <= '0;
      update_en    <= '0;
      busy         <= 1'b0;
      sample_valid <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      cnt          <= cnt_n;
      sweep_count  <= sc_n;
      update_en    <= (state_n == S_DWELL) ? (N'(1) << idx_n) : '0;
      busy         <= (state_n == S_DWELL) || (state_n == S_GAP) || (state_n == S_SWEEP_END);
      sample_valid <= (state_n == S_SWEEP_END);
      done         <= (state_n == S_DONE);
      if (latch) begin
        mask_q  <= enable_mask;
        dwell_q <= dwell_cycles;
        gap_q   <= gap_cycles;
        nsw_q   <= num_sweeps;
      end
    end
  end
endmodule

// File: tb/tb_pbit_sweep_scheduler.sv
// Directed-vector bench for pbit_sweep_scheduler with hand-derived strobe tables.
module tb_pbit_sweep_scheduler;
  localparam int N = 5, DW = 4, SW = 16;

  logic          CLK = 1'b0, RST = 1'b1, start = 1'b0, stop = 1'b0;
  logic [N-1:0]  enable_mask = '0;
  logic [DW-1:0] dwell_cycles = '0, gap_cycles = '0;
  logic [SW-1:0] num_sweeps = '0;
  logic [N-1:0]  update_en;
  logic          busy, sample_valid, done;
  logic [SW-1:0] sweep_count;

  int n_chk = 0, n_err = 0;

  pbit_sweep_scheduler #(.N(N), .DW(DW), .SW(SW)) dut (
    .CLK(CLK), .RST(RST), .start(start), .stop(stop),
    .enable_mask(enable_mask), .dwell_cycles(dwell_cycles),
    .gap_cycles(gap_cycles), .num_sweeps(num_sweeps),
    .update_en(update_en), .busy(busy), .sample_valid(sample_valid),
    .sweep_count(sweep_count), .done(done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Leaves the caller at the negedge of cycle 1 after the sampling edge.
  task automatic go(input logic [N-1:0] m, input logic [DW-1:0] d,
                    input logic [DW-1:0] g, input logic [SW-1:0] ns);
    @(negedge CLK);
    enable_mask = m; dwell_cycles = d; gap_cycles = g; num_sweeps = ns;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  logic [N-1:0] leg [16] = '{5'd1, 5'd1, 5'd0, 5'd2, 5'd2, 5'd0, 5'd4, 5'd4,
                             5'd0, 5'd8, 5'd8, 5'd0, 5'd16, 5'd16, 5'd0, 5'd0};
  logic [N-1:0] sp [3]   = '{5'b00100, 5'b10000, 5'd0};

  initial begin
    int sv_cnt, flags;
    // Reset state
    @(negedge CLK);
    chk("rst_upd", 32'(update_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sv", 32'(sample_valid), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_cnt", 32'(sweep_count), 0);
    RST = 1'b0;

    // Legacy 2-on/1-off pattern, two sweeps
    go(5'b11111, 4'd2, 4'd1, 16'd2);
    for (int k = 1; k <= 34; k++) begin
      if (k > 1) @(negedge CLK);
      chk($sformatf("leg_upd%0d", k), 32'(update_en), (k <= 32) ? 32'(leg[(k-1)%16]) : 0);
      chk($sformatf("leg_sv%0d", k), 32'(sample_valid), (k == 16 || k == 32) ? 1 : 0);
      chk($sformatf("leg_done%0d", k), 32'(done), (k == 33) ? 1 : 0);
      chk($sformatf("leg_busy%0d", k), 32'(busy), (k <= 32) ? 1 : 0);
      if (k == 33) chk("leg_cnt", 32'(sweep_count), 2);
    end

    // Sparse mask, three sweeps
    go(5'b10100, 4'd1, 4'd0, 16'd3);
    for (int k = 1; k <= 11; k++) begin
      if (k > 1) @(negedge CLK);
      chk($sformatf("sp_upd%0d", k), 32'(update_en), (k <= 9) ? 32'(sp[(k-1)%3]) : 0);
      chk($sformatf("sp_sv%0d", k), 32'(sample_valid), (k % 3 == 0 && k <= 9) ? 1 : 0);
      chk($sformatf("sp_done%0d", k), 32'(done), (k == 10) ? 1 : 0);
      if (k == 10) chk("sp_cnt", 32'(sweep_count), 3);
    end

    // Empty mask: straight to DONE, count cleared
    go(5'b00000, 4'd3, 4'd3, 16'd5);
    chk("emp_done1", 32'(done), 1);
    chk("emp_busy1", 32'(busy), 0);
    chk("emp_upd1", 32'(update_en), 0);
    chk("emp_cnt", 32'(sweep_count), 0);
    @(negedge CLK);
    chk("emp_done2", 32'(done), 0);
    chk("emp_upd2", 32'(update_en), 0);

    // Dwell 0 behaves as 1
    go(5'b00011, 4'd0, 4'd0, 16'd1);
    chk("dz_upd1", 32'(update_en), 1);
    chk("dz_busy1", 32'(busy), 1);
    @(negedge CLK);
    chk("dz_upd2", 32'(update_en), 2);
    @(negedge CLK);
    chk("dz_upd3", 32'(update_en), 0);
    chk("dz_sv3", 32'(sample_valid), 1);
    @(negedge CLK);
    chk("dz_done4", 32'(done), 1);
    chk("dz_busy4", 32'(busy), 0);
    chk("dz_cnt", 32'(sweep_count), 1);

    // Stop during second dwell of the second sweep
    go(5'b11111, 4'd2, 4'd1, 16'd0);
    for (int k = 2; k <= 20; k++) @(negedge CLK);
    chk("ab_upd20", 32'(update_en), 2);
    chk("ab_cnt20", 32'(sweep_count), 1);
    stop = 1'b1;
    @(negedge CLK);
    stop = 1'b0;
    chk("ab_upd", 32'(update_en), 0);
    chk("ab_busy", 32'(busy), 0);
    chk("ab_cnt", 32'(sweep_count), 1);
    flags = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      if (done || sample_valid || update_en != 0) flags++;
    end
    chk("ab_quiet", flags, 0);

    // Stop on the edge that would enter SWEEP_END
    go(5'b00001, 4'd1, 4'd0, 16'd0);
    @(negedge CLK);
    @(negedge CLK);
    chk("se_upd3", 32'(update_en), 1);
    chk("se_cnt3", 32'(sweep_count), 1);
    stop = 1'b1;
    @(negedge CLK);
    stop = 1'b0;
    chk("se_sv", 32'(sample_valid), 0);
    chk("se_cnt", 32'(sweep_count), 1);
    chk("se_busy", 32'(busy), 0);
    @(negedge CLK);
    chk("se_cnt_hold", 32'(sweep_count), 1);

    // Stop during the SWEEP_END cycle itself
    go(5'b00001, 4'd1, 4'd0, 16'd0);
    @(negedge CLK);
    chk("sx_sv2", 32'(sample_valid), 1);
    stop = 1'b1;
    @(negedge CLK);
    stop = 1'b0;
    chk("sx_cnt", 32'(sweep_count), 0);
    chk("sx_upd", 32'(update_en), 0);
    chk("sx_busy", 32'(busy), 0);

    // Asynchronous reset mid-strobe
    go(5'b11111, 4'd2, 4'd1, 16'd0);
    for (int k = 2; k <= 4; k++) @(negedge CLK);
    chk("rm_upd4", 32'(update_en), 2);
    #1 RST = 1'b1;
    #1;
    chk("rm_upd", 32'(update_en), 0);
    chk("rm_busy", 32'(busy), 0);
    chk("rm_sv", 32'(sample_valid), 0);
    chk("rm_done", 32'(done), 0);
    chk("rm_cnt", 32'(sweep_count), 0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;

    // Free-running run past 10 sweeps, then stop
    go(5'b00001, 4'd1, 4'd0, 16'd0);
    sv_cnt = 0;
    flags  = 0;
    for (int k = 1; k <= 31; k++) begin
      if (k > 1) @(negedge CLK);
      if (sample_valid) sv_cnt++;
      if (done) flags++;
      if (k == 30) chk("inf_cnt30", 32'(sweep_count), 14);
    end
    chk("inf_sv", sv_cnt, 15);
    chk("inf_nodone", flags, 0);
    chk("inf_upd31", 32'(update_en), 1);
    chk("inf_busy31", 32'(busy), 1);
    stop = 1'b1;
    @(negedge CLK);
    stop = 1'b0;
    chk("inf_cnt", 32'(sweep_count), 15);
    chk("inf_busy", 32'(busy), 0);
    chk("inf_upd", 32'(update_en), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
